dm_access_ctrl: RTL

- Load/store access controller between the pipeline MEM stage and the byte-addressed, little-endian 32-bit data memory.
- Accepts one request at a time over a valid/ready handshake.
- Performs word, halfword and byte loads with sign or zero extension.
- The memory only writes full words, so sub-word stores are done as read-modify-write.

---
 rtl/dm_access_ctrl_if.sv | 30 +++
 rtl/dm_access_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/dm_access_ctrl_if.sv
// Request/response and data-memory bus of the load/store access controller.
// master = pipeline + memory side, slave = dm_access_ctrl.
interface dm_access_ctrl_if #(
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_sign;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] dm_addr;
    logic              dm_we;
    logic [31:0]       dm_din;
    logic [31:0]       dm_dout;

    modport master (
        output req_valid, req_we, req_size, req_sign, req_addr, req_wdata, dm_dout,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, dm_addr, dm_we, dm_din
    );

    modport slave (
        input  req_valid, req_we, req_size, req_sign, req_addr, req_wdata, dm_dout,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, dm_addr, dm_we, dm_din
    );
endinterface

// File: rtl/dm_access_ctrl.sv
// Load/store controller for a little-endian word-wide data memory; sub-word stores are read-modify-write.
// Optional alignment/range rejection enabled by defining DM_ACCESS_ALIGN_CHECK_EN.
module dm_access_ctrl #(
    parameter int ADDR_W    = 16,
    parameter int MEM_BYTES = 12288
) (
    input logic             clk,
    input logic             rst_n,
    dm_access_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WRITE,
        RESP
    } state_e;

    state_e            state_q;
    logic              we_q;
    logic              sign_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       merged_q;
    logic [31:0]       rdata_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;

    logic [4:0]        lane_sel;
    logic [4:0]        half_sel;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [31:0]       load_d;
    logic [31:0]       merged_d;
    logic              acc_err;

    always_comb begin
        lane_sel = {addr_q[1:0], 3'b000};
        half_sel = {addr_q[1], 4'b0000};
        byte_v   = bus.dm_dout[lane_sel +: 8];
        half_v   = bus.dm_dout[half_sel +: 16];

        case (size_q)
            2'd0:    load_d = {{24{sign_q & byte_v[7]}}, byte_v};
            2'd1:    load_d = {{16{sign_q & half_v[15]}}, half_v};
            default: load_d = bus.dm_dout;
        endcase

        merged_d = bus.dm_dout;
        if (size_q == 2'd0) begin
            merged_d[lane_sel +: 8] = wdata_q[7:0];
        end else begin
            merged_d[half_sel +: 16] = wdata_q[15:0];
        end
    end

`ifdef DM_ACCESS_ALIGN_CHECK_EN
    logic              misalign;
    logic [ADDR_W-1:0] last_byte;

    // aligned + 3 is the aligned address with the two low bits set
    always_comb begin
        last_byte = {addr_q[ADDR_W-1:2], 2'b11};
        misalign  = ((size_q == 2'd1) && addr_q[0]) ||
                    (size_q[1] && (addr_q[1:0] != 2'b00));
        acc_err   = misalign || (32'(last_byte) >= 32'(MEM_BYTES));
    end
`else
    assign acc_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            sign_q      <= 1'b0;
            size_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            merged_q    <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q    <= bus.req_we;
                        size_q  <= bus.req_size;
                        sign_q  <= bus.req_sign;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (acc_err) begin
                        rdata_q     <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else if (!we_q) begin
                        rdata_q     <= load_d;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else if (size_q[1]) begin
                        rdata_q     <= '0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        merged_q <= merged_d;
                        state_q  <= WRITE;
                    end
                end
                WRITE: begin
                    rdata_q     <= '0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.dm_addr   = {addr_q[ADDR_W-1:2], 2'b00};
    // decoded from state so an async reset removes the write strobe at once
    assign bus.dm_we     = ((state_q == ACCESS) && we_q && size_q[1] && !acc_err) ||
                           (state_q == WRITE);
    assign bus.dm_din    = (state_q == WRITE) ? merged_q : wdata_q;

endmodule
